syscall_controller: RTL and testbench

//  Sequences SYSCALL execution for the 5-stage pipeline. On a SYSCALL in decode it stalls F/D and bubbles E.
//  It then waits until no in-flight write to $v0/$a0 remains in E/M/W.

---
 rtl/syscall_controller.sv | 143 ++++++++++++++
 tb/tb_syscall_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_controller.sv
// SYSCALL sequencer: stalls the front end, drains in-flight $v0/$a0 writes,
// samples the arguments, runs the console handshake and releases the pipeline.
module syscall_controller #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_syscall_d,
  input  logic [4:0]        write_reg_e,
  input  logic [4:0]        write_reg_m,
  input  logic [4:0]        write_reg_w,
  input  logic              sig_reg_write_e,
  input  logic              sig_reg_write_m,
  input  logic              sig_reg_write_w,
  input  logic [DATA_W-1:0] v0_data,
  input  logic [DATA_W-1:0] a0_data,
  input  logic              out_ready,
  output logic              syscall_stall,
  output logic              out_valid,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              halt,
  output logic              sys_error,
  output logic [CNT_W-1:0]  syscall_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SAMPLE = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] SVC_PRINT_INT  = DATA_W'(1);
  localparam logic [DATA_W-1:0] SVC_PRINT_CHAR = DATA_W'(11);
  localparam logic [DATA_W-1:0] SVC_EXIT       = DATA_W'(10);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state;
  state_t              next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                pending;
  logic                load_args;
  logic                set_error;
  logic                count_inc;
  logic                wait_clr;
  logic                wait_inc;
  logic                is_char;

  function automatic logic is_arg_reg(input logic we, input logic [4:0] rd);
    return we && ((rd == 5'd2) || (rd == 5'd4));
  endfunction

  // A char request carries only the low byte of $a0.
  function automatic logic [DATA_W-1:0] fmt_data(input logic chr, input logic [DATA_W-1:0] a0);
    return chr ? (a0 & DATA_W'(255)) : a0;
  endfunction

  assign pending = is_arg_reg(sig_reg_write_e, write_reg_e) ||
                   is_arg_reg(sig_reg_write_m, write_reg_m) ||
                   is_arg_reg(sig_reg_write_w, write_reg_w);

  assign is_char = (v0_data == SVC_PRINT_CHAR);

  assign syscall_stall = ((state == IDLE) && sig_syscall_d) || (state == DRAIN) ||
                         (state == SAMPLE) || (state == ISSUE) || (state == HALTED);
  assign out_valid     = (state == ISSUE);
  assign halt          = (state == HALTED);

  always_comb begin
    next_state = state;
    load_args  = 1'b0;
    set_error  = 1'b0;
    count_inc  = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      IDLE:   if (sig_syscall_d) next_state = DRAIN;
      DRAIN:  if (!pending) next_state = SAMPLE;
      SAMPLE: begin
        load_args = 1'b1;
        wait_clr  = 1'b1;
        if ((v0_data == SVC_PRINT_INT) || (v0_data == SVC_PRINT_CHAR)) begin
          next_state = ISSUE;
        end else if (v0_data == SVC_EXIT) begin
          next_state = HALTED;
          count_inc  = 1'b1;
        end else begin
          set_error  = 1'b1;
          next_state = DONE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          next_state = DONE;
          count_inc  = 1'b1;
        end else if (TIMEOUT != 0) begin
          if (wait_cnt == WAIT_LAST) begin
            set_error  = 1'b1;
            next_state = DONE;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      // DONE drops the stall for one cycle and ignores sig_syscall_d.
      DONE:    next_state = IDLE;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      out_kind      <= 2'd0;
      out_data      <= '0;
      sys_error     <= 1'b0;
      syscall_count <= '0;
    end else begin
      state <= next_state;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (load_args) begin
        out_kind <= is_char ? 2'd1 : 2'd0;
        out_data <= fmt_data(is_char, a0_data);
      end
      if (set_error) sys_error <= 1'b1;
      if (count_inc) syscall_count <= syscall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_syscall_controller.sv
// Directed bench for syscall_controller: one untimed instance and one with TIMEOUT=4.
module tb_syscall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_syscall_d;
  logic [4:0]  write_reg_e, write_reg_m, write_reg_w;
  logic        sig_reg_write_e, sig_reg_write_m, sig_reg_write_w;
  logic [31:0] v0_data, a0_data;
  logic        out_ready;

  logic        stall_a, valid_a, halt_a, err_a;
  logic [1:0]  kind_a;
  logic [31:0] data_a;
  logic [15:0] count_a;
  logic        stall_b, valid_b, halt_b, err_b;
  logic [1:0]  kind_b;
  logic [31:0] data_b;
  logic [15:0] count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  syscall_controller #(.DATA_W(32), .CNT_W(16), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_syscall_d(sig_syscall_d),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .sig_reg_write_e(sig_reg_write_e), .sig_reg_write_m(sig_reg_write_m),
    .sig_reg_write_w(sig_reg_write_w), .v0_data(v0_data), .a0_data(a0_data),
    .out_ready(out_ready), .syscall_stall(stall_a), .out_valid(valid_a),
    .out_kind(kind_a), .out_data(data_a), .halt(halt_a), .sys_error(err_a),
    .syscall_count(count_a)
  );

  syscall_controller #(.DATA_W(32), .CNT_W(16), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_syscall_d(sig_syscall_d),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .sig_reg_write_e(sig_reg_write_e), .sig_reg_write_m(sig_reg_write_m),
    .sig_reg_write_w(sig_reg_write_w), .v0_data(v0_data), .a0_data(a0_data),
    .out_ready(out_ready), .syscall_stall(stall_b), .out_valid(valid_b),
    .out_kind(kind_b), .out_data(data_b), .halt(halt_b), .sys_error(err_b),
    .syscall_count(count_b)
  );

  task automatic clear_inputs();
    sig_syscall_d   = 1'b0;
    write_reg_e     = 5'd0;
    write_reg_m     = 5'd0;
    write_reg_w     = 5'd0;
    sig_reg_write_e = 1'b0;
    sig_reg_write_m = 1'b0;
    sig_reg_write_w = 1'b0;
    v0_data         = 32'd0;
    a0_data         = 32'd0;
    out_ready       = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if ({stall_a, valid_a, kind_a, data_a, halt_a, err_a, count_a} !== 53'd0) begin
      n_bad++;
      $display("FAIL reset_a got stall=%b valid=%b kind=%0d data=%0h halt=%b err=%b count=%0d required all 0",
               stall_a, valid_a, kind_a, data_a, halt_a, err_a, count_a);
    end
    n_cmp++;
    if ({stall_b, valid_b, kind_b, data_b, halt_b, err_b, count_b} !== 53'd0) begin
      n_bad++;
      $display("FAIL reset_b got stall=%b valid=%b kind=%0d data=%0h halt=%b err=%b count=%0d required all 0",
               stall_b, valid_b, kind_b, data_b, halt_b, err_b, count_b);
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({stall_a, valid_a, halt_a, err_a, count_a} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_release got stall=%b valid=%b halt=%b err=%b count=%0d required all 0",
               stall_a, valid_a, halt_a, err_a, count_a);
    end
  endtask

  task automatic test_print_int();
    logic [4:0] exp_stall = 5'b01111;
    logic [4:0] exp_valid = 5'b01000;
    apply_reset();
    v0_data = 32'd1; a0_data = 32'd42; out_ready = 1'b1; sig_syscall_d = 1'b1;
    write_reg_m = 5'd3; sig_reg_write_m = 1'b1;  // non-argument write: never pending
    write_reg_e = 5'd2; sig_reg_write_e = 1'b0;  // argument reg but no write enable
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_a, valid_a} !== {exp_stall[k], exp_valid[k]}) begin
        n_bad++;
        $display("FAIL int_ctrl cyc%0d got stall,valid=%b required %b", k,
                 {stall_a, valid_a}, {exp_stall[k], exp_valid[k]});
      end
      if (k == 3) begin
        n_cmp++;
        if (kind_a !== 2'd0 || data_a !== 32'd42) begin
          n_bad++;
          $display("FAIL int_payload got kind=%0d data=%0d required kind=0 data=42", kind_a, data_a);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (count_a !== 16'd1 || err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL int_count got count=%0d err=%b required count=1 err=0", count_a, err_a);
    end
  endtask

  task automatic test_drain();
    logic [6:0] exp_stall = 7'b0111111;
    logic [6:0] exp_valid = 7'b0100000;
    apply_reset();
    v0_data = 32'd1; a0_data = 32'd7; out_ready = 1'b1; sig_syscall_d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      sig_reg_write_e = (k == 0); write_reg_e = (k == 0) ? 5'd4 : 5'd0;
      sig_reg_write_m = (k == 1); write_reg_m = (k == 1) ? 5'd4 : 5'd0;
      sig_reg_write_w = (k == 2); write_reg_w = (k == 2) ? 5'd4 : 5'd0;
      a0_data = (k >= 3) ? 32'd100 : 32'd7;
      @(negedge clk);
      n_cmp++;
      if ({stall_a, valid_a} !== {exp_stall[k], exp_valid[k]}) begin
        n_bad++;
        $display("FAIL drain_ctrl cyc%0d got stall,valid=%b required %b", k,
                 {stall_a, valid_a}, {exp_stall[k], exp_valid[k]});
      end
      if (k == 5) begin
        n_cmp++;
        if (data_a !== 32'd100) begin
          n_bad++;
          $display("FAIL drain_data got %0d required 100", data_a);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (count_a !== 16'd1) begin
      n_bad++;
      $display("FAIL drain_count got %0d required 1", count_a);
    end
  endtask

  task automatic test_char_backpressure();
    logic [9:0] exp_stall = 10'b0111111111;
    logic [9:0] exp_valid = 10'b0111111000;
    apply_reset();
    v0_data = 32'd11; a0_data = 32'h141; sig_syscall_d = 1'b1;
    for (int k = 0; k < 11; k++) begin
      out_ready = (k >= 8);
      if (k == 10) sig_syscall_d = 1'b0;
      @(negedge clk);
      if (k < 10) begin
        n_cmp++;
        if ({stall_a, valid_a} !== {exp_stall[k], exp_valid[k]}) begin
          n_bad++;
          $display("FAIL char_ctrl cyc%0d got stall,valid=%b required %b", k,
                   {stall_a, valid_a}, {exp_stall[k], exp_valid[k]});
        end
        if (exp_valid[k]) begin
          n_cmp++;
          if (kind_a !== 2'd1 || data_a !== 32'h41) begin
            n_bad++;
            $display("FAIL char_payload cyc%0d got kind=%0d data=%0h required kind=1 data=41",
                     k, kind_a, data_a);
          end
        end
      end else begin
        n_cmp++;
        if (count_a !== 16'd1 || valid_a !== 1'b0) begin
          n_bad++;
          $display("FAIL char_count got count=%0d valid=%b required count=1 valid=0", count_a, valid_a);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_stall = 8'b01111111;
    logic [7:0] exp_valid = 8'b01111000;
    apply_reset();
    v0_data = 32'd1; a0_data = 32'd5; out_ready = 1'b0; sig_syscall_d = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_b, valid_b} !== {exp_stall[k], exp_valid[k]}) begin
        n_bad++;
        $display("FAIL tmo_ctrl cyc%0d got stall,valid=%b required %b", k,
                 {stall_b, valid_b}, {exp_stall[k], exp_valid[k]});
      end
      if (k >= 6) begin
        n_cmp++;
        if (err_b !== (k == 7) || count_b !== 16'd0) begin
          n_bad++;
          $display("FAIL tmo_err cyc%0d got err=%b count=%0d required err=%b count=0",
                   k, err_b, count_b, (k == 7));
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_halt_and_reset();
    logic [6:0] exp_halt = 7'b1111000;
    apply_reset();
    v0_data = 32'd10; out_ready = 1'b1; sig_syscall_d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_a, halt_a, valid_a} !== {1'b1, exp_halt[k], 1'b0}) begin
        n_bad++;
        $display("FAIL halt_ctrl cyc%0d got stall,halt,valid=%b required %b", k,
                 {stall_a, halt_a, valid_a}, {1'b1, exp_halt[k], 1'b0});
      end
      if (k == 3) begin
        n_cmp++;
        if (count_a !== 16'd1) begin
          n_bad++;
          $display("FAIL halt_count got %0d required 1", count_a);
        end
      end
      @(posedge clk); #1;
    end
    apply_reset();
    v0_data = 32'd1; a0_data = 32'h55; out_ready = 1'b0; sig_syscall_d = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (valid_a !== 1'b1 || data_a !== 32'h55) begin
      n_bad++;
      $display("FAIL midissue got valid=%b data=%0h required valid=1 data=55", valid_a, data_a);
    end
    #2;
    rst_n = 1'b0;
    sig_syscall_d = 1'b0;
    #1;
    n_cmp++;
    if ({stall_a, valid_a, kind_a, data_a, halt_a, err_a, count_a} !== 53'd0) begin
      n_bad++;
      $display("FAIL async_reset got stall=%b valid=%b kind=%0d data=%0h halt=%b err=%b count=%0d required all 0",
               stall_a, valid_a, kind_a, data_a, halt_a, err_a, count_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_stall = 9'b011110111;
    logic [8:0] exp_valid = 9'b010000000;
    apply_reset();
    a0_data = 32'd99; out_ready = 1'b1; sig_syscall_d = 1'b1;
    for (int k = 0; k < 9; k++) begin
      v0_data = (k < 4) ? 32'd7 : 32'd1;
      @(negedge clk);
      n_cmp++;
      if ({stall_a, valid_a} !== {exp_stall[k], exp_valid[k]}) begin
        n_bad++;
        $display("FAIL b2b_ctrl cyc%0d got stall,valid=%b required %b", k,
                 {stall_a, valid_a}, {exp_stall[k], exp_valid[k]});
      end
      if (k == 3 || k == 8) begin
        n_cmp++;
        if (err_a !== 1'b1 || count_a !== ((k == 8) ? 16'd1 : 16'd0)) begin
          n_bad++;
          $display("FAIL b2b_status cyc%0d got err=%b count=%0d required err=1 count=%0d",
                   k, err_a, count_a, (k == 8) ? 1 : 0);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (data_a !== 32'd99 || kind_a !== 2'd0) begin
          n_bad++;
          $display("FAIL b2b_payload got kind=%0d data=%0d required kind=0 data=99", kind_a, data_a);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_print_int();
    test_drain();
    test_char_backpressure();
    test_timeout();
    test_halt_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
